memory_cycle: RTL
=================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports RegWrite_M, ResultSrc_M, MemWrite_M  input  1 each  memory-stage controls from execute stage; ResultSrc_M=1 marks a load.
REQ-004 SHALL have ports AluResult_M, WriteData_M  input  32 each  address/ALU result and store data.
REQ-005 SHALL have ports dmem_req, dmem_we  output  1 each  data-memory request and write enable.
REQ-006 SHALL have ports dmem_addr, dmem_wdata  output  32 each  memory address and store data.
REQ-007 SHALL have ports dmem_rdata  input  32 and dmem_ack  input  1  read data and completion acknowledge.
REQ-008 SHALL have port Stall_M  output  1  freezes fetch/decode/execute while high.
REQ-009 SHALL have ports RegWrite_W, ResultSrc_W  output  1 each, and AluResult_W, ReadData_W  output  32 each  writeback-stage register.
REQ-010 SHALL have port mem_fault  output  1  sticky timeout flag.

Function
REQ-011 SHALL define access = ResultSrc_M | MemWrite_M.
REQ-012 SHALL implement FSM with states IDLE and WAIT.
REQ-013 SHALL drive dmem_req = !rst & ((IDLE & access) | WAIT), combinationally.
REQ-014 SHALL drive dmem_addr=AluResult_M, dmem_wdata=WriteData_M, dmem_we=MemWrite_M whenever dmem_req is high.
REQ-015 SHALL treat an access as complete on a rising edge where dmem_req and dmem_ack are both high; zero-wait memory (ack in the request cycle) SHALL produce no stall.
REQ-016 SHALL drive Stall_M = dmem_req & !dmem_ack & !timeout, combinationally.
REQ-017 SHALL transition IDLE->WAIT when access & !dmem_ack; WAIT->IDLE on dmem_ack or timeout; otherwise hold.
REQ-018 SHALL, on each non-stalled rising edge, load RegWrite_W, ResultSrc_W, AluResult_W from M inputs and ReadData_W from dmem_rdata (ReadData_W=0 when no load).
REQ-019 SHALL, on each stalled rising edge, load a bubble: RegWrite_W=0, ResultSrc_W=0, AluResult_W=0, ReadData_W=0.
REQ-020 SHALL ignore dmem_ack while dmem_req is low.
REQ-021 SHALL use 1-cycle latency from completion edge to W outputs; an instruction without access SHALL pass M->W in exactly one cycle.

Reset
REQ-022 SHALL, on a rising edge with rst=1, set state=IDLE, RegWrite_W=0, ResultSrc_W=0, AluResult_W=0, ReadData_W=0, mem_fault=0, timeout counter=0.
REQ-023 SHALL, while rst=1, hold dmem_req=0 and Stall_M=0; a reset during WAIT SHALL abandon the access without writeback.

Configuration
REQ-024 SHALL, with MEM_TIMEOUT_EN defined, count consecutive WAIT cycles with dmem_ack=0 in a 4-bit counter cleared on entering WAIT.
REQ-025 SHALL, with MEM_TIMEOUT_EN defined, assert timeout when counter=15 and dmem_ack=0; that edge completes the access with RegWrite_W=0, ResultSrc_W=0, sets mem_fault=1 until reset, returns to IDLE.
REQ-026 SHALL, without MEM_TIMEOUT_EN, wait in WAIT indefinitely, omit the counter, tie timeout=0 and mem_fault=0.

Verification
REQ-027 SHALL check zero-wait load: AluResult_M=0x100, ResultSrc_M=1, RegWrite_M=1, dmem_ack=1 same cycle, dmem_rdata=0xCAFEF00D -> Stall_M never high; next cycle ReadData_W=0xCAFEF00D, RegWrite_W=1.
REQ-028 SHALL check 3-wait store: MemWrite_M=1, addr 0x200, data 0x12345678, ack after 3 cycles -> Stall_M high 3 cycles, dmem_we=1, addr/data stable, 3 bubbles on W, then RegWrite_W=0.
REQ-029 SHALL check ALU-only op: AluResult_M=0x55, RegWrite_M=1, access=0 -> dmem_req=0; next cycle AluResult_W=0x55, RegWrite_W=1.
REQ-030 SHALL check reset mid-WAIT: load pending 2 cycles, rst=1 one cycle -> state IDLE, W outputs zero, dmem_req=0 during reset.
REQ-031 SHALL check timeout (MEM_TIMEOUT_EN): load, ack never -> Stall_M high 16 cycles, then mem_fault=1, RegWrite_W=0, next access proceeds normally.
REQ-032 SHALL check stray ack: dmem_ack=1 with access=0 for 5 cycles -> no state change, mem_fault=0.

Source files
------------

// File: rtl/memory_cycle.sv
// memory_cycle -- memory stage of the pipeline plus the M->W pipeline register.
//
// Issues loads/stores to a data memory with a req/ack handshake. A zero-wait
// memory (ack in the request cycle) completes without stalling. Otherwise the
// stage freezes fetch/decode/execute (Stall_M) and pushes bubbles into
// writeback until the access is acknowledged.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, an access that has waited 15 consecutive WAIT cycles without
//   ack is abandoned on the next edge. Nothing is written back, and the sticky
//   mem_fault flag is set until reset. When undefined, WAIT lasts until ack and
//   mem_fault is tied low.
//
// Ports:
//   clk, rst                             clock, synchronous active-high reset
//   RegWrite_M, ResultSrc_M, MemWrite_M  controls from execute (ResultSrc_M=1: load)
//   AluResult_M, WriteData_M             address/ALU result and store data
//   dmem_req, dmem_we                    memory request / write enable (combinational)
//   dmem_addr, dmem_wdata                memory address / store data (combinational)
//   dmem_rdata, dmem_ack                 memory read data / completion acknowledge
//   Stall_M                              freezes upstream stages while high
//   RegWrite_W, ResultSrc_W,
//   AluResult_W, ReadData_W              registered writeback-stage outputs
//   mem_fault                            sticky timeout flag
module memory_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite_M,
  input  logic        ResultSrc_M,
  input  logic        MemWrite_M,
  input  logic [31:0] AluResult_M,
  input  logic [31:0] WriteData_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        Stall_M,
  output logic        RegWrite_W,
  output logic        ResultSrc_W,
  output logic [31:0] AluResult_W,
  output logic [31:0] ReadData_W,
  output logic        mem_fault
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_r;
  state_t stateNext_s;
  logic   access_s;
  logic   timeout_s;

  assign access_s = ResultSrc_M | MemWrite_M;

`ifdef MEM_TIMEOUT_EN
  logic [3:0] waitCnt_r;
  logic       memFault_r;

  // The access has used up its wait budget when the counter is at 15 and
  // the memory still has not acknowledged.
  assign timeout_s = !rst && (state_r == WAIT) && (waitCnt_r == 4'd15) && !dmem_ack;
  assign mem_fault = memFault_r;

  // Wait counter: held at zero in IDLE, so it always starts from zero on
  // entering WAIT. It then counts WAIT cycles without ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      waitCnt_r <= 4'd0;
    end else if (state_r == IDLE) begin
      waitCnt_r <= 4'd0;
    end else if (!dmem_ack) begin
      waitCnt_r <= waitCnt_r + 4'd1;
    end else begin
      waitCnt_r <= waitCnt_r;
    end
  end

  // Sticky fault flag: set by a timeout and cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      memFault_r <= 1'b0;
    end else if (timeout_s) begin
      memFault_r <= 1'b1;
    end else begin
      memFault_r <= memFault_r;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign mem_fault = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next state, memory request and stall. All are forced quiet during reset,
  // so an access in flight is dropped.
  always_comb begin
    stateNext_s = state_r;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    dmem_addr   = 32'd0;
    dmem_wdata  = 32'd0;
    Stall_M     = 1'b0;
    if (rst) begin
      stateNext_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s) begin
            dmem_req = 1'b1;
            // An ack in the request cycle completes the access in place.
            if (dmem_ack) begin
              stateNext_s = IDLE;
            end else begin
              stateNext_s = WAIT;
            end
          end else begin
            stateNext_s = IDLE;
          end
        end
        WAIT: begin
          dmem_req = 1'b1;
          if (dmem_ack || timeout_s) begin
            stateNext_s = IDLE;
          end else begin
            stateNext_s = WAIT;
          end
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
      // Upstream is frozen while stalled, so M inputs stay stable for the
      // whole access.
      if (dmem_req) begin
        dmem_we    = MemWrite_M;
        dmem_addr  = AluResult_M;
        dmem_wdata = WriteData_M;
      end else begin
        dmem_we    = 1'b0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
      end
      Stall_M = dmem_req & !dmem_ack & !timeout_s;
    end
  end

  // M->W pipeline register. A stalled edge or an abandoned (timed-out)
  // access inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_W  <= 1'b0;
      ResultSrc_W <= 1'b0;
      AluResult_W <= 32'd0;
      ReadData_W  <= 32'd0;
    end else if (Stall_M || timeout_s) begin
      RegWrite_W  <= 1'b0;
      ResultSrc_W <= 1'b0;
      AluResult_W <= 32'd0;
      ReadData_W  <= 32'd0;
    end else begin
      RegWrite_W  <= RegWrite_M;
      ResultSrc_W <= ResultSrc_M;
      AluResult_W <= AluResult_M;
      ReadData_W  <= ResultSrc_M ? dmem_rdata : 32'd0;
    end
  end

endmodule
